mem_arbiter: RTL and testbench

Two-port arbiter sharing the single 256-bit data memory between the data cache (port 0) and the instruction cache (port 1). Each cache presents its level-held miss/write-back request exactly as it would drive memory directly. The arbiter grants one port at a time with round-robin priority and latches that port's command onto the memory bus. It routes `mem_ack_i` back only to the granted port, and inserts a one-cycle release gap so a cache's trailing enable is not re-arbitrated. A watchdog flags memory transactions that never acknowledge.

---
 rtl/mem_arb_pkg.sv | 22 ++
 rtl/mem_arb_watchdog.sv | 43 ++++
 rtl/mem_arbiter.sv | 128 ++++++++++++
 tb/tb_mem_arbiter.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types, port indices and default widths for the two-port memory arbiter.
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 256;

  localparam int DCACHE = 0;
  localparam int ICACHE = 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2
  } arb_state_e;

  // Returns the port index to grant; on a tie the port that did not win last time.
  function automatic logic rr_pick(input logic req0, input logic req1, input logic last_grant);
    if (req0 && req1) return ~last_grant;
    return req1;
  endfunction

endpackage

// File: rtl/mem_arb_watchdog.sv
// Saturating BUSY-cycle counter with a sticky flag that stays set until reset.
module mem_arb_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic count_en,
  input  logic clear,
  output logic timeout_o
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;

  always_comb begin
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    if (clear) begin
      cnt_d = '0;
    end else if (count_en && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
    // TIMEOUT of zero leaves the flag permanently clear
    if ((TIMEOUT != 0) && (cnt_d == CNT_W'(TIMEOUT))) begin
      timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_o = timeout_q;

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one line-wide memory between the data cache (port 0)
// and the instruction cache (port 1), with a release gap and an ack watchdog.
//   state   | meaning
//   IDLE    | sample requests, grant and latch command on the way out
//   BUSY    | command held on the memory bus, waiting for mem_ack_i
//   RELEASE | one dead cycle so a trailing enable is not re-arbitrated
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              p0_enable_i,
  input  logic              p0_write_i,
  input  logic [ADDR_W-1:0] p0_addr_i,
  input  logic [DATA_W-1:0] p0_data_i,
  output logic [DATA_W-1:0] p0_data_o,
  output logic              p0_ack_o,
  input  logic              p1_enable_i,
  input  logic              p1_write_i,
  input  logic [ADDR_W-1:0] p1_addr_i,
  input  logic [DATA_W-1:0] p1_data_i,
  output logic [DATA_W-1:0] p1_data_o,
  output logic              p1_ack_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o,
  input  logic [DATA_W-1:0] mem_data_i,
  input  logic              mem_ack_i,
  output logic [1:0]        grant_o,
  output logic              timeout_o
);

  arb_state_e        state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic [1:0]        grant_q, grant_d;
  logic              mem_enable_q, mem_enable_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_data_q, mem_data_d;
  logic              pick;
  logic              wd_clear;
  logic              busy;

  assign busy = (state_q == BUSY);

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    mem_enable_d = mem_enable_q;
    mem_write_d  = mem_write_q;
    mem_addr_d   = mem_addr_q;
    mem_data_d   = mem_data_q;
    wd_clear     = 1'b0;
    pick         = rr_pick(p0_enable_i, p1_enable_i, last_grant_q);
    case (state_q)
      IDLE: begin
        if (p0_enable_i || p1_enable_i) begin
          state_d      = BUSY;
          last_grant_d = pick;
          grant_d      = pick ? 2'b10 : 2'b01;
          mem_enable_d = 1'b1;
          mem_write_d  = pick ? p1_write_i : p0_write_i;
          mem_addr_d   = pick ? p1_addr_i  : p0_addr_i;
          mem_data_d   = pick ? p1_data_i  : p0_data_i;
          wd_clear     = 1'b1;
        end
      end
      BUSY: begin
        // Address and data are left holding their last value after completion
        if (mem_ack_i) begin
          state_d      = RELEASE;
          grant_d      = 2'b00;
          mem_enable_d = 1'b0;
          mem_write_d  = 1'b0;
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      grant_q      <= 2'b00;
      mem_enable_q <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      mem_enable_q <= mem_enable_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
    end
  end

  mem_arb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .count_en  (busy),
    .clear     (wd_clear),
    .timeout_o (timeout_o)
  );

  assign p0_ack_o     = mem_ack_i & grant_q[DCACHE] & busy;
  assign p1_ack_o     = mem_ack_i & grant_q[ICACHE] & busy;
  assign p0_data_o    = mem_data_i;
  assign p1_data_o    = mem_data_i;
  assign mem_enable_o = mem_enable_q;
  assign mem_write_o  = mem_write_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_data_o   = mem_data_q;
  assign grant_o      = grant_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, single request, tie, alternation,
// write-back then fill, watchdog and reset during a transaction.
module tb_mem_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 256;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b0;
  logic              p0_enable_i = 1'b0, p0_write_i = 1'b0;
  logic [ADDR_W-1:0] p0_addr_i = '0;
  logic [DATA_W-1:0] p0_data_i = '0;
  logic [DATA_W-1:0] p0_data_o;
  logic              p0_ack_o;
  logic              p1_enable_i = 1'b0, p1_write_i = 1'b0;
  logic [ADDR_W-1:0] p1_addr_i = '0;
  logic [DATA_W-1:0] p1_data_i = '0;
  logic [DATA_W-1:0] p1_data_o;
  logic              p1_ack_o;
  logic              mem_enable_o, mem_write_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_data_o;
  logic [DATA_W-1:0] mem_data_i = '0;
  logic              mem_ack_i = 1'b0;
  logic [1:0]        grant_o;
  logic              timeout_o;

  int vectors = 0;
  int errs    = 0;

  localparam logic [DATA_W-1:0] LINE_A = {8{32'hA5A5_0001}};
  localparam logic [DATA_W-1:0] LINE_B = {8{32'h5A5A_0002}};
  localparam logic [DATA_W-1:0] LINE_C = {8{32'hC0DE_0003}};

  mem_arbiter #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .TIMEOUT (8)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .p0_enable_i  (p0_enable_i),
    .p0_write_i   (p0_write_i),
    .p0_addr_i    (p0_addr_i),
    .p0_data_i    (p0_data_i),
    .p0_data_o    (p0_data_o),
    .p0_ack_o     (p0_ack_o),
    .p1_enable_i  (p1_enable_i),
    .p1_write_i   (p1_write_i),
    .p1_addr_i    (p1_addr_i),
    .p1_data_i    (p1_data_i),
    .p1_data_o    (p1_data_o),
    .p1_ack_o     (p1_ack_o),
    .mem_enable_o (mem_enable_o),
    .mem_write_o  (mem_write_o),
    .mem_addr_o   (mem_addr_o),
    .mem_data_o   (mem_data_o),
    .mem_data_i   (mem_data_i),
    .mem_ack_i    (mem_ack_i),
    .grant_o      (grant_o),
    .timeout_o    (timeout_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_i = 1'b0;
    tick();
    tick();
    rst_i = 1'b1;
    tick();
  endtask

  initial begin
    // Reset values
    mem_data_i = LINE_B;
    tick();
    tick();
    chk("rst_enable", mem_enable_o, 0);
    chk("rst_write", mem_write_o, 0);
    chk("rst_addr", mem_addr_o, 0);
    chk("rst_data", mem_data_o, 0);
    chk("rst_grant", grant_o, 0);
    chk("rst_timeout", timeout_o, 0);
    chk("rst_p0_data", p0_data_o, LINE_B);
    chk("rst_p1_data", p1_data_o, LINE_B);
    rst_i = 1'b1;
    tick();

    // Single p0 fill, ack in the 10th BUSY cycle
    p0_enable_i = 1'b1; p0_write_i = 1'b0; p0_addr_i = 32'h0000_0400;
    tick();
    for (int i = 1; i <= 9; i++) begin
      chk("single_enable", mem_enable_o, 1);
      chk("single_grant", grant_o, 2'b01);
      chk("single_addr", mem_addr_o, 32'h400);
      chk("single_write", mem_write_o, 0);
      chk("single_p0_ack_early", p0_ack_o, 0);
      tick();
    end
    chk("single_enable_c10", mem_enable_o, 1);
    mem_ack_i = 1'b1; mem_data_i = LINE_A;
    #1;
    chk("single_p0_ack", p0_ack_o, 1);
    chk("single_p1_ack", p1_ack_o, 0);
    chk("single_p0_data", p0_data_o, LINE_A);
    p0_enable_i = 1'b0;
    tick();
    mem_ack_i = 1'b0;
    #1;
    chk("single_rel_enable", mem_enable_o, 0);
    chk("single_rel_grant", grant_o, 0);
    chk("single_rel_addr_hold", mem_addr_o, 32'h400);
    chk("single_rel_p0_ack", p0_ack_o, 0);

    // Tie after reset: p0 first, p1 three cycles after p0's ack
    do_reset();
    p0_enable_i = 1'b1; p0_addr_i = 32'h0000_0100;
    p1_enable_i = 1'b1; p1_write_i = 1'b0; p1_addr_i = 32'h0000_0200;
    tick();
    chk("tie_grant_first", grant_o, 2'b01);
    chk("tie_addr_first", mem_addr_o, 32'h100);
    tick();
    mem_ack_i = 1'b1;
    #1;
    chk("tie_p0_ack", p0_ack_o, 1);
    chk("tie_p1_ack_none", p1_ack_o, 0);
    p0_enable_i = 1'b0;
    tick();
    #1;
    chk("tie_grant_m1", grant_o, 2'b00);
    chk("tie_rel_ack_dropped", p0_ack_o | p1_ack_o, 0);
    mem_ack_i = 1'b0;
    tick();
    chk("tie_grant_m2", grant_o, 2'b00);
    chk("tie_enable_m2", mem_enable_o, 0);
    tick();
    chk("tie_grant_m3", grant_o, 2'b10);
    chk("tie_addr_second", mem_addr_o, 32'h200);
    mem_ack_i = 1'b1;
    #1;
    chk("tie_p1_ack", p1_ack_o, 1);
    chk("tie_p0_ack_none", p0_ack_o, 0);
    p1_enable_i = 1'b0;
    tick();
    mem_ack_i = 1'b0;

    // Alternation: both hold requests for four transactions, last winner was p1
    p0_enable_i = 1'b1; p1_enable_i = 1'b1;
    tick();
    chk("alt_idle_grant", grant_o, 2'b00);
    for (int t = 0; t < 4; t++) begin
      tick();
      chk("alt_grant", grant_o, (t % 2 == 0) ? 2'b01 : 2'b10);
      mem_ack_i = 1'b1;
      #1;
      chk("alt_p0_ack", p0_ack_o, (t % 2 == 0) ? 1 : 0);
      chk("alt_p1_ack", p1_ack_o, (t % 2 == 0) ? 0 : 1);
      tick();
      mem_ack_i = 1'b0;
      tick();
    end
    p0_enable_i = 1'b0; p1_enable_i = 1'b0;

    // Write-back then fill with p0 enable held, p1 pending
    do_reset();
    p0_enable_i = 1'b1; p0_write_i = 1'b1; p0_addr_i = 32'h0000_1020; p0_data_i = LINE_A;
    p1_enable_i = 1'b1; p1_write_i = 1'b0; p1_addr_i = 32'h0000_0300; p1_data_i = LINE_C;
    tick();
    chk("wb_grant", grant_o, 2'b01);
    chk("wb_write", mem_write_o, 1);
    chk("wb_addr", mem_addr_o, 32'h1020);
    chk("wb_data", mem_data_o, LINE_A);
    tick();
    mem_ack_i = 1'b1;
    p0_write_i = 1'b0; p0_addr_i = 32'h0000_0020;
    #1;
    chk("wb_p0_ack", p0_ack_o, 1);
    chk("wb_addr_stable", mem_addr_o, 32'h1020);
    chk("wb_write_stable", mem_write_o, 1);
    tick();
    mem_ack_i = 1'b0;
    tick();
    tick();
    chk("wb_second_grant", grant_o, 2'b10);
    chk("wb_second_addr", mem_addr_o, 32'h300);
    chk("wb_second_write", mem_write_o, 0);
    mem_ack_i = 1'b1;
    #1;
    chk("wb_p1_ack", p1_ack_o, 1);
    p1_enable_i = 1'b0;
    tick();
    mem_ack_i = 1'b0;
    tick();
    tick();
    chk("wb_fill_grant", grant_o, 2'b01);
    chk("wb_fill_addr", mem_addr_o, 32'h20);
    chk("wb_fill_write", mem_write_o, 0);
    mem_ack_i = 1'b1;
    #1;
    chk("wb_fill_ack", p0_ack_o, 1);
    p0_enable_i = 1'b0;
    tick();
    mem_ack_i = 1'b0;
    tick();

    // Watchdog with TIMEOUT=8 and a late ack
    do_reset();
    p1_enable_i = 1'b1; p1_addr_i = 32'h0000_0500;
    tick();
    chk("wd_grant", grant_o, 2'b10);
    chk("wd_start", timeout_o, 0);
    for (int i = 0; i < 7; i++) tick();
    chk("wd_before_limit", timeout_o, 0);
    tick();
    chk("wd_at_limit", timeout_o, 1);
    for (int i = 0; i < 5; i++) tick();
    chk("wd_still_waiting", mem_enable_o, 1);
    chk("wd_sticky_busy", timeout_o, 1);
    mem_ack_i = 1'b1;
    #1;
    chk("wd_late_ack", p1_ack_o, 1);
    p1_enable_i = 1'b0;
    tick();
    mem_ack_i = 1'b0;
    #1;
    chk("wd_sticky_release", timeout_o, 1);
    chk("wd_release_enable", mem_enable_o, 0);
    tick();

    // Reset during BUSY cycle 3, then a stale ack, then a fresh p1 request
    p0_enable_i = 1'b1; p0_write_i = 1'b1; p0_addr_i = 32'h0000_0600;
    tick();
    chk("mid_grant", grant_o, 2'b01);
    tick();
    tick();
    rst_i = 1'b0;
    #1;
    chk("mid_enable", mem_enable_o, 0);
    chk("mid_write", mem_write_o, 0);
    chk("mid_addr", mem_addr_o, 0);
    chk("mid_grant_cleared", grant_o, 0);
    chk("mid_timeout", timeout_o, 0);
    p0_enable_i = 1'b0;
    tick();
    rst_i = 1'b1;
    tick();
    mem_ack_i = 1'b1;
    #1;
    chk("mid_stale_p0_ack", p0_ack_o, 0);
    chk("mid_stale_p1_ack", p1_ack_o, 0);
    tick();
    mem_ack_i = 1'b0;
    p1_enable_i = 1'b1; p1_write_i = 1'b0; p1_addr_i = 32'h0000_0700;
    tick();
    chk("mid_next_grant", grant_o, 2'b10);
    chk("mid_next_addr", mem_addr_o, 32'h700);
    mem_ack_i = 1'b1;
    #1;
    chk("mid_next_ack", p1_ack_o, 1);
    p1_enable_i = 1'b0;
    tick();
    mem_ack_i = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
